// File: rtl/axi3_master_if.sv
// AXI3 bus bundle for a single-beat master: AW, W, B, AR and R channels.
// The master modport drives requests, and the slave modport drives the responses.
interface axi3_master_if #(
   parameter int ADDR = 32,
   parameter int DATA = 32,
   parameter int ID   = 12
);
   logic              awvalid;
   logic              awready;
   logic [ADDR-1:0]   awaddr;
   logic [3:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic [1:0]        awlock;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic [3:0]        awqos;
   logic [ID-1:0]     awid;

   logic              wvalid;
   logic              wready;
   logic [DATA-1:0]   wdata;
   logic [DATA/8-1:0] wstrb;
   logic              wlast;
   logic [ID-1:0]     wid;

   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic [ID-1:0]     bid;

   logic              arvalid;
   logic              arready;
   logic [ADDR-1:0]   araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [1:0]        arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic [ID-1:0]     arid;

   logic              rvalid;
   logic              rready;
   logic [DATA-1:0]   rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID-1:0]     rid;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast, wid,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast, wid,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready
   );
endinterface

// File: rtl/axi3_master.sv
// Simple-request to AXI3 bridge: each request becomes one single-beat write or read.
// A one-cycle inack pulse ends each transaction, and inerr carries the slave error status with it.
module axi3_master #(
   parameter int ADDR = 32,
   parameter int DATA = 32,
   parameter int ID   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR-1:0]   inaddr,
   input  logic [DATA-1:0]   inwdata,
   input  logic [DATA/8-1:0] inwstrb,
   input  logic              inwr,
   input  logic              inreq,
   output logic [DATA-1:0]   inrdata,
   output logic              inack,
   output logic              inerr,
   axi3_master_if.master     axi
);

   localparam logic [2:0] BEAT_SIZE = (DATA == 64) ? 3'd3 : 3'd2;

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR-1:0]   addr_q;
   logic [DATA-1:0]   wdata_q;
   logic [DATA/8-1:0] wstrb_q;
   logic              err_q;
   logic              aw_done;
   logic              w_done;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              ar_hs;
   logic              r_hs;
   logic              unused_resp;

   assign aw_hs = axi.awvalid & axi.awready;
   assign w_hs  = axi.wvalid  & axi.wready;
   assign b_hs  = axi.bvalid  & axi.bready;
   assign ar_hs = axi.arvalid & axi.arready;
   assign r_hs  = axi.rvalid  & axi.rready;

   // Response IDs and the low response bit (OKAY vs EXOKAY) carry no meaning here
   assign unused_resp = ^{axi.bid, axi.rid, axi.bresp[0], axi.rresp[0]};

   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 4'd0;
   assign axi.awsize  = BEAT_SIZE;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'b0011;
   assign axi.awprot  = 3'd0;
   assign axi.awqos   = 4'd0;
   assign axi.awid    = '0;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = 1'b1;
   assign axi.wid     = '0;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = BEAT_SIZE;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0011;
   assign axi.arprot  = 3'd0;
   assign axi.arqos   = 4'd0;
   assign axi.arid    = '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err_q   <= 1'b0;
         inrdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               if (inreq) begin
                  addr_q  <= inaddr;
                  wdata_q <= inwdata;
                  wstrb_q <= inwstrb;
               end
            end
            WRITE: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            WRESP: if (b_hs) err_q <= axi.bresp[1];
            RDATA: if (r_hs) begin
               inrdata <= axi.rdata;
               err_q   <= axi.rresp[1] | ~axi.rlast;
            end
            default: ;
         endcase
      end
   end

   // AW and W complete independently; leave WRITE once each has been seen, past or present
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (inreq) state_nx = inwr ? WRITE : READ;
         WRITE: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = WRESP;
         WRESP: if (b_hs) state_nx = DONE;
         READ:  if (ar_hs) state_nx = RDATA;
         RDATA: if (r_hs) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      inack       = 1'b0;
      inerr       = 1'b0;
      case (state)
         WRITE: begin
            axi.awvalid = ~aw_done;
            axi.wvalid  = ~w_done;
         end
         WRESP: axi.bready  = 1'b1;
         READ:  axi.arvalid = 1'b1;
         RDATA: axi.rready  = 1'b1;
         DONE: begin
            inack = 1'b1;
            inerr = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi3_master.sv
// Bench for axi3_master: a slave with programmable per-channel delays, directed cases, then random transactions.
// Expected latency, error and read data come from transaction-level rules, not from the RTL structure.
module tb_axi3_master;
   localparam int ADDR = 32;
   localparam int DATA = 32;
   localparam int ID   = 12;

   logic            clk = 1'b0;
   logic            reset;
   logic [ADDR-1:0] inaddr;
   logic [DATA-1:0] inwdata;
   logic [3:0]      inwstrb;
   logic            inwr;
   logic            inreq;
   logic [DATA-1:0] inrdata;
   logic            inack;
   logic            inerr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi3_master_if #(.ADDR(ADDR), .DATA(DATA), .ID(ID)) axi ();

   axi3_master #(.ADDR(ADDR), .DATA(DATA), .ID(ID)) dut (
      .clk     (clk),
      .reset   (reset),
      .inaddr  (inaddr),
      .inwdata (inwdata),
      .inwstrb (inwstrb),
      .inwr    (inwr),
      .inreq   (inreq),
      .inrdata (inrdata),
      .inack   (inack),
      .inerr   (inerr),
      .axi     (axi)
   );

   // Slave configuration
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
   logic        r_last_v = 1'b1;
   logic [31:0] r_data_v = '0;

   int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic aw_seen, w_seen, b_pend, r_pend;

   assign axi.awready = (aw_cnt >= aw_dly);
   assign axi.wready  = (w_cnt >= w_dly);
   assign axi.arready = (ar_cnt >= ar_dly);
   assign axi.bvalid  = b_pend && (b_cnt >= b_dly);
   assign axi.bresp   = b_resp_v;
   assign axi.bid     = 12'h005;
   assign axi.rvalid  = r_pend && (r_cnt >= r_dly);
   assign axi.rdata   = r_data_v;
   assign axi.rresp   = r_resp_v;
   assign axi.rlast   = r_last_v;
   assign axi.rid     = 12'h007;

   always @(posedge clk) begin
      if (reset) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      end else begin
         if (axi.awvalid && axi.awready) aw_cnt <= 0;
         else if (axi.awvalid)           aw_cnt <= aw_cnt + 1;
         if (axi.wvalid && axi.wready)   w_cnt <= 0;
         else if (axi.wvalid)            w_cnt <= w_cnt + 1;
         if (axi.arvalid && axi.arready) ar_cnt <= 0;
         else if (axi.arvalid)           ar_cnt <= ar_cnt + 1;

         if (axi.bvalid && axi.bready) begin
            b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0;
         end else begin
            if (axi.awvalid && axi.awready) aw_seen <= 1'b1;
            if (axi.wvalid && axi.wready)   w_seen  <= 1'b1;
            if (b_pend) b_cnt <= b_cnt + 1;
            else if ((aw_seen || (axi.awvalid && axi.awready)) &&
                     (w_seen  || (axi.wvalid  && axi.wready))) begin
               b_pend <= 1'b1; b_cnt <= 0;
            end
         end

         if (axi.rvalid && axi.rready) r_pend <= 1'b0;
         else if (r_pend)              r_cnt <= r_cnt + 1;
         else if (axi.arvalid && axi.arready) begin
            r_pend <= 1'b1; r_cnt <= 0;
         end
      end
   end

   // Bus monitor: handshake counts and the values seen at each handshake
   int          aw_n = 0, w_n = 0, ar_n = 0, ack_n = 0;
   logic [31:0] mon_awaddr, mon_wdata, mon_araddr;
   logic [3:0]  mon_wstrb;
   logic [33:0] mon_aw_attr, mon_ar_attr;
   logic [12:0] mon_w_tail;

   always @(posedge clk) begin
      if (axi.awvalid && axi.awready) begin
         aw_n <= aw_n + 1;
         mon_awaddr  <= axi.awaddr;
         mon_aw_attr <= {axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                         axi.awprot, axi.awqos, axi.awid};
      end
      if (axi.wvalid && axi.wready) begin
         w_n <= w_n + 1;
         mon_wdata  <= axi.wdata;
         mon_wstrb  <= axi.wstrb;
         mon_w_tail <= {axi.wlast, axi.wid};
      end
      if (axi.arvalid && axi.arready) begin
         ar_n <= ar_n + 1;
         mon_araddr  <= axi.araddr;
         mon_ar_attr <= {axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
                         axi.arprot, axi.arqos, axi.arid};
      end
      if (inack) ack_n <= ack_n + 1;
   end

   logic        av_hist [64];
   logic        wv_hist [64];
   logic [31:0] rd_model = '0;
   logic [33:0] attr_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request; returns the cycle (inreq cycle = 0) on which inack was seen
   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int poke, output int lat);
      @(posedge clk); #1;
      inaddr = a; inwdata = d; inwstrb = s; inwr = wr; inreq = 1'b1;
      @(posedge clk); #1;
      inreq = 1'b0; inaddr = ~a; inwdata = ~d; inwstrb = ~s;
      lat = 1;
      while (!inack && lat < 60) begin
         av_hist[lat] = axi.awvalid;
         wv_hist[lat] = axi.wvalid;
         if (lat == poke) inreq = 1'b1;
         @(posedge clk); #1;
         inreq = 1'b0;
         lat++;
      end
   endtask

   task automatic do_txn(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input int poke);
      int   lat, exp_lat, aw0, w0, ar0, ack0;
      logic exp_err;
      aw0 = aw_n; w0 = w_n; ar0 = ar_n; ack0 = ack_n;
      exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      exp_err = wr ? b_resp_v[1] : (r_resp_v[1] | ~r_last_v);
      if (!wr) rd_model = r_data_v;
      run_txn(wr, a, d, s, poke, lat);
      check({tag, ".lat"},   64'(lat), 64'(exp_lat));
      check({tag, ".ack"},   64'(inack), 64'd1);
      check({tag, ".err"},   64'(inerr), 64'(exp_err));
      check({tag, ".rdata"}, 64'(inrdata), 64'(rd_model));
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".ackcnt"}, 64'(ack_n - ack0), 64'd1);
      check({tag, ".ackoff"}, 64'(inack), 64'd0);
      if (wr) begin
         check({tag, ".awn"},    64'(aw_n - aw0), 64'd1);
         check({tag, ".wn"},     64'(w_n - w0), 64'd1);
         check({tag, ".arn"},    64'(ar_n - ar0), 64'd0);
         check({tag, ".awaddr"}, 64'(mon_awaddr), 64'(a));
         check({tag, ".wdata"},  64'(mon_wdata), 64'(d));
         check({tag, ".wstrb"},  64'(mon_wstrb), 64'(s));
         check({tag, ".awattr"}, 64'(mon_aw_attr), 64'(attr_exp));
         check({tag, ".wlast"},  64'(mon_w_tail), 64'({1'b1, 12'd0}));
      end else begin
         check({tag, ".arn"},    64'(ar_n - ar0), 64'd1);
         check({tag, ".awn"},    64'(aw_n - aw0), 64'd0);
         check({tag, ".araddr"}, 64'(mon_araddr), 64'(a));
         check({tag, ".arattr"}, 64'(mon_ar_attr), 64'(attr_exp));
      end
   endtask

   initial begin
      int ack0, ar0;
      logic        wr;
      logic [31:0] a, d;
      logic [3:0]  s;

      attr_exp = {4'd0, 3'd2, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0, 12'd0};
      reset = 1'b1; inreq = 1'b0; inwr = 1'b0;
      inaddr = '0; inwdata = '0; inwstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.ctl", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                              inack, inerr}), 64'd0);
      check("reset.rdata", 64'(inrdata), 64'd0);
      reset = 1'b0;

      // Basic write, immediate responses
      do_txn("wr_basic", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0);

      // awready lags wready by 3 cycles
      aw_dly = 3;
      do_txn("wr_awlag", 1'b1, 32'h44, 32'h0BADF00D, 4'h3, 0);
      check("wr_awlag.wv1", 64'(wv_hist[1]), 64'd1);
      check("wr_awlag.wv2", 64'(wv_hist[2]), 64'd0);
      check("wr_awlag.av2", 64'(av_hist[2]), 64'd1);
      check("wr_awlag.av4", 64'(av_hist[4]), 64'd1);
      check("wr_awlag.av5", 64'(av_hist[5]), 64'd0);
      aw_dly = 0;

      // Reads: clean, SLVERR, missing rlast, EXOKAY
      r_data_v = 32'h12345678;
      do_txn("rd_basic", 1'b0, 32'h80, 32'h0, 4'h0, 0);
      r_data_v = 32'hCAFEF00D; r_resp_v = 2'b10;
      do_txn("rd_slverr", 1'b0, 32'h84, 32'h0, 4'h0, 0);
      b_resp_v = 2'b11;
      do_txn("wr_decerr", 1'b1, 32'h88, 32'h11223344, 4'hC, 0);
      b_resp_v = 2'b01;
      do_txn("wr_exokay", 1'b1, 32'h8C, 32'h55667788, 4'h1, 0);
      r_resp_v = 2'b00; r_last_v = 1'b0; r_data_v = 32'hA5A5A5A5;
      do_txn("rd_nolast", 1'b0, 32'h90, 32'h0, 4'h0, 0);
      r_last_v = 1'b1; r_resp_v = 2'b01; r_data_v = 32'h5A5A5A5A;
      do_txn("rd_exokay", 1'b0, 32'h94, 32'h0, 4'h0, 0);
      r_resp_v = 2'b00; b_resp_v = 2'b00;

      // inreq pulsed while waiting in RDATA
      r_dly = 4; r_data_v = 32'h01020304;
      do_txn("rd_poke", 1'b0, 32'hA0, 32'h0, 4'h0, 3);
      r_dly = 0;

      // Reset while waiting for the write response
      b_dly = 10;
      ack0 = ack_n;
      @(posedge clk); #1;
      inaddr = 32'hB0; inwdata = 32'hFFFF0000; inwstrb = 4'hF; inwr = 1'b1; inreq = 1'b1;
      @(posedge clk); #1;
      inreq = 1'b0;
      @(posedge clk); #1;
      check("rst_wresp.bready_before", 64'(axi.bready), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_wresp.ctl", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                                  inack}), 64'd0);
      reset = 1'b0;
      rd_model = '0;
      repeat (12) @(posedge clk);
      #1;
      check("rst_wresp.noack", 64'(ack_n - ack0), 64'd0);
      b_dly = 0;
      r_data_v = 32'h600DCAFE;
      do_txn("rd_after_rst", 1'b0, 32'hC0, 32'h0, 4'h0, 0);

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = $urandom & 32'hFFFF_FFFC;
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         aw_dly = $urandom_range(0, 3);
         w_dly  = $urandom_range(0, 3);
         b_dly  = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3);
         r_dly  = $urandom_range(0, 3);
         b_resp_v = 2'($urandom_range(0, 3));
         r_resp_v = 2'($urandom_range(0, 3));
         r_last_v = ($urandom_range(0, 3) != 0);
         r_data_v = $urandom;
         ar0 = ar_n;
         do_txn($sformatf("rand%0d", i), wr, a, d, s, 0);
         if (!wr) check($sformatf("rand%0d.single_ar", i), 64'(ar_n - ar0), 64'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
